// File: rtl/fir_sample_feeder_if.sv
// Sample-feeder bus: upstream valid/ready push side, FIR-facing issue side, status.
// Latency: none (wires only).
// Backpressure: s_ready is driven by the feeder; valid_in is a pulse with no ready.
//
// Macro FIR_FEEDER_LOCKSTEP_EN adds fir_valid_out (FIR result strobe back to the feeder).
// master: producer/controller side.  slave: the feeder itself.
interface fir_sample_feeder_if #(
    parameter int DEPTH = 8
) ();
    logic                     s_valid;
    logic [7:0]               s_data;
    logic                     s_ready;
    logic                     run;
    logic                     valid_in;
    logic [7:0]               x;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     busy;
`ifdef FIR_FEEDER_LOCKSTEP_EN
    logic                     fir_valid_out;

    modport master (
        output s_valid, s_data, run, fir_valid_out,
        input  s_ready, valid_in, x, fifo_count, busy
    );
    modport slave (
        input  s_valid, s_data, run, fir_valid_out,
        output s_ready, valid_in, x, fifo_count, busy
    );
`else
    modport master (
        output s_valid, s_data, run,
        input  s_ready, valid_in, x, fifo_count, busy
    );
    modport slave (
        input  s_valid, s_data, run,
        output s_ready, valid_in, x, fifo_count, busy
    );
`endif
endinterface

// File: rtl/fir_sample_feeder.sv
// Buffers 8-bit samples and issues them to the FIR as valid_in/x pulses >= SPACING cycles apart.
// Latency: sample pushed at edge E0 with run=1 and idle FSM -> valid_in/x registered at E1.
// Backpressure: s_ready = occupancy < DEPTH (no bypass when full); low while reset is held.
//
// Ports: clock, reset (async, active-low), bus (fir_sample_feeder_if.slave):
//   s_valid/s_data/s_ready push side, run issue enable, valid_in/x to FIR, fifo_count, busy.
// Optional: FIR_FEEDER_LOCKSTEP_EN also waits for a fir_valid_out strobe before the next issue.
module fir_sample_feeder #(
    parameter int DEPTH   = 8,
    parameter int SPACING = 10,
    parameter int CW      = 4
) (
    input  logic                clock,
    input  logic                reset,
    fir_sample_feeder_if.slave  bus
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]    ONE_CNT  = (AW+1)'(1);
    localparam logic [CW-1:0]  GAP_LOAD = CW'(SPACING - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [CW-1:0]   gap_q, gap_d;
    logic            valid_in_q, valid_in_d;
    logic [7:0]      x_q, x_d;
    logic [7:0]      mem_q [DEPTH];

    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            lock_ok;

    assign fifo_empty = (count_q == '0);
    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even in the cycle it pops.
    assign push       = bus.s_valid && (count_q != FULL_CNT);

`ifdef FIR_FEEDER_LOCKSTEP_EN
    // Sticky "FIR has produced its result since the last issue"; the live strobe
    // counts too so the issue can follow it on the very next edge.
    logic seen_q, seen_d;

    assign lock_ok = seen_q || bus.fir_valid_out;

    always_comb begin
        seen_d = lock_ok;
        if (pop) begin
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end
`else
    assign lock_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        valid_in_d = 1'b0;
        x_d        = x_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && bus.run) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // ISSUE and the load edge account for two of the SPACING cycles.
                state_d = WAIT;
                gap_d   = GAP_LOAD;
            end
            WAIT: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - CW'(1);
                end else if (lock_ok) begin
                    state_d = (!fifo_empty && bus.run) ? ISSUE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs and the pop are taken on the edge that enters ISSUE, so the
        // pulse coincides with the ISSUE cycle.
        if (state_d == ISSUE) begin
            pop        = 1'b1;
            valid_in_d = 1'b1;
            x_d        = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            valid_in_q <= 1'b0;
            x_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            valid_in_q <= valid_in_d;
            x_q        <= x_d;
        end
    end

    // Storage needs no reset: entries are only read below the registered count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.s_ready    = reset && (count_q != FULL_CNT);
    assign bus.valid_in   = valid_in_q;
    assign bus.x          = x_q;
    assign bus.fifo_count = count_q;
    assign bus.busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;

    localparam int DEPTH   = 8;
    localparam int SPACING = 10;

    logic clock;
    logic reset;

    fir_sample_feeder_if #(.DEPTH(DEPTH)) bus ();

    fir_sample_feeder #(.DEPTH(DEPTH), .SPACING(SPACING), .CW(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       sv;
        logic [7:0] d;
        logic       run;
        logic       ev;
        logic [7:0] ex;
        int         ec;
        logic       er;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic sv, input logic [7:0] d, input logic rn);
        bus.s_valid = sv;
        bus.s_data  = d;
        bus.run     = rn;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        set_in(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         pulses;
        int         peak;
        int         pc[$];
        logic [7:0] pd[$];
        logic [7:0] q[$];
        int         last;
        logic       sv, rn, ready, issue;
        logic [7:0] d, ex;

        // Single sample 0x5A, then fill to full with run low, then drain one.
        tbl[0] = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            tbl[4+i] = '{1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 8'h5A,
                         (i < 8) ? i + 1 : 8, (i < 7)};
        end
        tbl[13] = '{1'b1, 8'h19, 1'b1, 1'b1, 8'h11, 7, 1'b1};
        tbl[14] = '{1'b1, 8'h19, 1'b0, 1'b0, 8'h11, 8, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 8, 1'b0};

`ifdef FIR_FEEDER_LOCKSTEP_EN
        bus.fir_valid_out = 1'b1;
`endif
        reset = 1'b0;
        set_in(1'b0, 8'h00, 1'b0);
        #12;
        check("reset_valid_in", 32'(bus.valid_in), 32'd0);
        check("reset_x", 32'(bus.x), 32'h00);
        check("reset_count", 32'(bus.fifo_count), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_s_ready_held", 32'(bus.s_ready), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("reset_s_ready_released", 32'(bus.s_ready), 32'd1);

        // Table-driven vectors
        foreach (tbl[i]) begin
            set_in(tbl[i].sv, tbl[i].d, tbl[i].run);
            tick();
            check($sformatf("tbl%0d_valid_in", i), 32'(bus.valid_in), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_x", i), 32'(bus.x), 32'(tbl[i].ex));
            check($sformatf("tbl%0d_count", i), 32'(bus.fifo_count), 32'(tbl[i].ec));
            check($sformatf("tbl%0d_s_ready", i), 32'(bus.s_ready), 32'(tbl[i].er));
        end

        // Burst 0x01..0x08 with run high
        reset_dut();
        peak = 0;
        for (int c = 0; c < 120; c++) begin
            if (c < 8) set_in(1'b1, 8'(c + 1), 1'b1);
            else       set_in(1'b0, 8'h00, 1'b1);
            tick();
            if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
            if (bus.valid_in) begin
                pc.push_back(c);
                pd.push_back(bus.x);
            end
        end
        check("burst_pulse_count", 32'(pc.size()), 32'd8);
        for (int k = 0; k < pc.size() && k < 8; k++) begin
            check($sformatf("burst_data%0d", k), 32'(pd[k]), 32'(k + 1));
            if (k > 0) check($sformatf("burst_gap%0d", k), 32'(pc[k] - pc[k-1]), 32'(SPACING));
        end
        check("burst_peak_7_or_8", 32'(peak == 7 || peak == 8), 32'd1);

        // run gating
        reset_dut();
        set_in(1'b1, 8'hA1, 1'b1);
        tick();
        set_in(1'b1, 8'hB2, 1'b1);
        tick();
        check("gate_first_pulse", 32'(bus.valid_in), 32'd1);
        check("gate_first_x", 32'(bus.x), 32'hA1);
        set_in(1'b0, 8'h00, 1'b1);
        tick();
        tick();
        tick();
        bus.run = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.valid_in) pulses++;
        end
        check("gate_no_pulse_run_low", 32'(pulses), 32'd0);
        check("gate_holds_x", 32'(bus.x), 32'hA1);
        bus.run = 1'b1;
        tick();
        check("gate_resume_pulse", 32'(bus.valid_in), 32'd1);
        check("gate_resume_x", 32'(bus.x), 32'hB2);
        tick();
        check("gate_pulse_one_cycle", 32'(bus.valid_in), 32'd0);

        // Reset mid-stream with 3 samples queued
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 8'(8'h31 + k), 1'b0);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0);
        check("midrst_queued", 32'(bus.fifo_count), 32'd3);
        reset = 1'b0;
        #1;
        check("midrst_valid_in", 32'(bus.valid_in), 32'd0);
        check("midrst_x", 32'(bus.x), 32'h00);
        check("midrst_count", 32'(bus.fifo_count), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
        tick();
        reset = 1'b1;
        bus.run = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.valid_in) pulses++;
        end
        check("midrst_no_stale_issue", 32'(pulses), 32'd0);

`ifdef FIR_FEEDER_LOCKSTEP_EN
        // Lockstep: second issue waits for the FIR result strobe
        reset_dut();
        bus.fir_valid_out = 1'b0;
        set_in(1'b1, 8'hC1, 1'b1);
        tick();
        set_in(1'b1, 8'hC2, 1'b1);
        tick();
        check("lock_first_pulse", 32'(bus.valid_in), 32'd1);
        set_in(1'b0, 8'h00, 1'b1);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.valid_in) pulses++;
        end
        check("lock_withheld", 32'(pulses), 32'd0);
        bus.fir_valid_out = 1'b1;
        tick();
        bus.fir_valid_out = 1'b0;
        check("lock_release_pulse", 32'(bus.valid_in), 32'd1);
        check("lock_release_x", 32'(bus.x), 32'hC2);
        bus.fir_valid_out = 1'b1;
`endif

        // Randomized run against the issue-rule model:
        // an issue happens at an edge iff the queue is non-empty, run is high,
        // and at least SPACING edges have passed since the previous issue.
        reset_dut();
        q    = {};
        last = -100;
        ex   = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if (((i / 250) % 2) == 1) sv = ($urandom_range(0, 15) == 0);
            else                      sv = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 7) != 0);
            d  = 8'($urandom);
            set_in(sv, d, rn);
            ready = (q.size() < DEPTH);
            issue = (q.size() > 0) && rn && (i - last >= SPACING);
            if (issue) begin
                ex   = q.pop_front();
                last = i;
            end
            if (sv && ready) q.push_back(d);
            tick();
            check("rand_valid_in", 32'(bus.valid_in), 32'(issue));
            check("rand_x", 32'(bus.x), 32'(ex));
            check("rand_count", 32'(bus.fifo_count), 32'(q.size()));
            check("rand_s_ready", 32'(bus.s_ready), 32'(q.size() < DEPTH));
            check("rand_busy", 32'(bus.busy), 32'((q.size() > 0) || (i - last < SPACING)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
